sdram_responder: RTL and testbench
==================================

# sdram_responder

Avalon-MM slave memory responder: the target end of the SDRAM-facing master port used by the copy/accelerator engines. It holds a word-addressed array behind a byte-addressed bus and answers pipelined reads with fixed-latency `readdatavalid`. It applies `waitrequest` backpressure when its read pipeline is full or a refresh stall is active. It is the on-chip stand-in for off-chip SDRAM in block-level and system benches.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words stored; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; 4-byte aligned.
- `READ_LATENCY`, 2: cycles from accepted read to `readdatavalid`; range 1..8.
- `MAX_PENDING`, 4: maximum in-flight reads before `waitrequest` asserts; range 1..8.
- `REFRESH_PERIOD`, 256 / `REFRESH_CYCLES`, 4: refresh interval and refresh stall length in cycles. Used only with the refresh macro.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `slave_address` in 32: byte address.
- `slave_read` in 1: read request.
- `slave_write` in 1: write request.
- `slave_writedata` in 32: write data.
- `slave_waitrequest` out 1: request not accepted this cycle.
- `slave_readdata` out 32: read data; meaningful only while `slave_readdatavalid` is high.
- `slave_readdatavalid` out 1: one-cycle pulse per returned word.
- `err_count` out 16: saturating count of bad accesses.

## Operation
- Acceptance: a request is accepted on a rising edge where `(read|write) && !slave_waitrequest`. The master must hold address, data and command stable while `waitrequest` is high.
- Decode: `off = address - BASE_ADDR`. The access is valid iff `off[1:0]==0` and `off < 4*DEPTH_WORDS`. Word index is `off >> 2`, truncated to `$clog2(DEPTH_WORDS)` bits.
- Write:
  - Valid: the array word is updated on the accepting edge.
  - Invalid: dropped; `err_count` increments.
- Read:
  - Valid: the array word, sampled at the accepting edge, enters the read pipeline.
  - Invalid: 32'hDEAD_BEEF enters the pipeline and `err_count` increments.
- Every accepted read returns exactly one response, in order.
- `read` and `write` both high: treated as a write only; `err_count` increments and no read response is produced.
- Pending counter: +1 on read accept, −1 on `readdatavalid`, both in the same cycle gives net 0. Range 0..MAX_PENDING.
- `slave_waitrequest = (pending == MAX_PENDING && !readdatavalid_this_cycle) || stall`. Combinational from registered state; never depends on `read`/`write` in the same cycle.
- `err_count` saturates at 16'hFFFF.
- State machine (refresh build):
  - READY → STALL when the refresh counter reaches `REFRESH_PERIOD-1`.
  - STALL → READY after `REFRESH_CYCLES` cycles.
  - In STALL: `stall=1`; in-flight reads still complete on schedule.
  - Without the macro the FSM is permanently READY.

## Timing
- Read accepted at edge N → `slave_readdatavalid=1` during the cycle after edge N+READ_LATENCY−1. With default latency 2, data appears two edges after acceptance.
- Back-to-back reads sustain 1 word/cycle whenever `MAX_PENDING ≥ READ_LATENCY`.
- Write latency 0: a read accepted on the edge after a write to the same address returns the new data. A read and write to the same address accepted on the same edge cannot occur (write wins).
- Reset values: `slave_waitrequest=1` while `rst` is high, 0 on the first cycle after release. `slave_readdatavalid=0`, `slave_readdata=0`, `err_count=0`, pending=0, FSM=READY, refresh counter=0.
- Reset mid-operation: the pipeline is flushed and in-flight reads never return. Array contents are not cleared.

## Configuration
- `SDRAM_RESP_REFRESH_EN` defined: refresh counter and STALL state are compiled in. `waitrequest` goes high for `REFRESH_CYCLES` every `REFRESH_PERIOD` cycles, independent of traffic.
- Not defined: no refresh logic; `stall` is tied to 0; `waitrequest` depends only on pending reads.

## Structure
- Shared package `sdram_resp_pkg`:
  - FSM enum `{READY, STALL}`.
  - Constant `BAD_READ_DATA = 32'hDEAD_BEEF`.
  - Default latency and pending constants.
- Sub-module `read_pipe`: a `READ_LATENCY`-deep shift register of {valid, data} with flush on `rst`. It produces `slave_readdatavalid` and `slave_readdata`.
- The array, decode, pending counter and FSM live in the top module.

## Test plan
- Reset, then write 32'h1234_5678 at BASE+0x10, then read BASE+0x10 → `readdatavalid` two edges after accept with data 32'h1234_5678; `err_count=0`.
- Ten back-to-back reads of BASE+0x00..0x24 with defaults → ten consecutive valid pulses, in order, no `waitrequest`.
- MAX_PENDING=1, READ_LATENCY=3, continuous reads → `waitrequest` high 2 of every 3 cycles; every response is correct.
- Read of BASE+4*DEPTH_WORDS, a write to BASE+0x2, then read+write together → data 32'hDEAD_BEEF, `err_count=3`, array unchanged except the simultaneous write.
- With `SDRAM_RESP_REFRESH_EN`, PERIOD=16, CYCLES=4, continuous reads → `waitrequest` high cycles 16–19, 36–39, …; no lost or duplicated responses.
- Assert `rst` with 2 reads in flight → no `readdatavalid` afterwards; a post-reset read of a previously written word returns the old value.

Source files
------------

// File: rtl/sdram_responder_pkg.sv
// Shared types and constants for the sdram_responder block: FSM state
// encoding, the poison word returned for bad reads, default sizing and
// the saturating error-counter helper.
package sdram_resp_pkg;

    typedef enum logic [0:0] {
        READY = 1'b0,
        STALL = 1'b1
    } resp_state_e;

    localparam logic [31:0] BAD_READ_DATA = 32'hDEAD_BEEF;

    localparam int DEF_DEPTH_WORDS  = 1024;
    localparam int DEF_READ_LATENCY = 2;
    localparam int DEF_MAX_PENDING  = 4;

    // Increment a 16-bit counter, sticking at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// Avalon-MM slave bus between an SDRAM-facing master and sdram_responder.
interface sdram_responder_if;

    logic [31:0] slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;

    modport master (
        output slave_address,
        output slave_read,
        output slave_write,
        output slave_writedata,
        input  slave_waitrequest,
        input  slave_readdata,
        input  slave_readdatavalid
    );

    modport slave (
        input  slave_address,
        input  slave_read,
        input  slave_write,
        input  slave_writedata,
        output slave_waitrequest,
        output slave_readdata,
        output slave_readdatavalid
    );

endinterface

// File: rtl/sdram_responder_read_pipe.sv
// Fixed-latency read return path: a LATENCY-deep shift register of
// {valid, data}. The last stage drives readdatavalid/readdata directly,
// so both outputs are registered. Reset flushes every stage, which is how
// in-flight reads are discarded.
module read_pipe #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_data
);

    logic [LATENCY-1:0] valid_r;
    logic [31:0]        data_r [LATENCY];

    // Shift accepted reads toward the output, clearing everything on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_r[i] <= 32'd0;
            end
        end else begin
            valid_r[0] <= in_valid;
            data_r[0]  <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[LATENCY-1];
    assign out_data  = data_r[LATENCY-1];

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: on-chip Avalon-MM memory target standing in for SDRAM.
// Word array behind a byte-addressed bus, fixed-latency pipelined reads,
// waitrequest backpressure on a full read pipeline or refresh stall, and a
// saturating count of bad accesses.
// Optional feature: define SDRAM_RESP_REFRESH_EN to enable periodic refresh
// stalls (REFRESH_CYCLES of waitrequest every REFRESH_PERIOD cycles).
module sdram_responder
    import sdram_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS    = DEF_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          READ_LATENCY   = DEF_READ_LATENCY,
    parameter int          MAX_PENDING    = DEF_MAX_PENDING,
    parameter int          REFRESH_PERIOD = 256,
    parameter int          REFRESH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    sdram_responder_if.slave  bus,
    output logic [15:0]       err_count
);

`ifdef SDRAM_RESP_REFRESH_EN
    localparam bit REFRESH_EN = 1'b1;
`else
    localparam bit REFRESH_EN = 1'b0;
`endif

    localparam int AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PW   = $clog2(MAX_PENDING + 1);
    localparam int RP_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int RC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [32:0]     SPAN_BYTES  = 33'(DEPTH_WORDS) << 2;
    localparam logic [PW-1:0]   PEND_MAX    = PW'(MAX_PENDING);
    localparam logic [RP_W-1:0] RP_LAST     = RP_W'(REFRESH_PERIOD - 1);
    localparam logic [RC_W-1:0] RC_LAST     = RC_W'(REFRESH_CYCLES - 1);

    logic [31:0]     mem_r [DEPTH_WORDS];
    logic [31:0]     off_s;
    logic            addr_ok_s;
    logic [AW-1:0]   idx_s;
    logic            accept_s;
    logic            wr_acc_s;
    logic            rd_acc_s;
    logic            err_s;
    logic [31:0]     rd_data_s;
    logic            stall_s;
    logic [PW-1:0]   pending_r;
    logic [15:0]     err_count_r;
    resp_state_e     state_r;
    logic [RP_W-1:0] refresh_cnt_r;
    logic [RC_W-1:0] stall_cnt_r;

    // Address decode relative to BASE_ADDR and request qualification.
    always_comb begin
        off_s     = bus.slave_address - BASE_ADDR;
        addr_ok_s = (off_s[1:0] == 2'b00) && ({1'b0, off_s} < SPAN_BYTES);
        idx_s     = off_s[AW+1:2];
        accept_s  = (bus.slave_read | bus.slave_write) & ~bus.slave_waitrequest;
        // A simultaneous read+write is serviced as a write only.
        wr_acc_s  = accept_s & bus.slave_write;
        rd_acc_s  = accept_s & bus.slave_read & ~bus.slave_write;
        err_s     = accept_s & (~addr_ok_s | (bus.slave_read & bus.slave_write));
    end

    // Read data entering the pipeline: array word or poison for bad reads.
    always_comb begin
        if (addr_ok_s) begin
            rd_data_s = mem_r[idx_s];
        end else begin
            rd_data_s = BAD_READ_DATA;
        end
    end

    // Backpressure from registered state only; reset forces it high.
    assign stall_s = (state_r == STALL);
    assign bus.slave_waitrequest = rst
                                 | ((pending_r == PEND_MAX) & ~bus.slave_readdatavalid)
                                 | stall_s;

    // Word array: valid writes land on the accepting edge; never reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s && addr_ok_s) begin
            mem_r[idx_s] <= bus.slave_writedata;
        end
    end

    read_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_acc_s),
        .in_data   (rd_data_s),
        .out_valid (bus.slave_readdatavalid),
        .out_data  (bus.slave_readdata)
    );

    // In-flight read count: up on accept, down on return, net zero if both.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= '0;
        end else begin
            case ({rd_acc_s, bus.slave_readdatavalid})
                2'b10:   pending_r <= pending_r + PW'(1);
                2'b01:   pending_r <= pending_r - PW'(1);
                default: pending_r <= pending_r;
            endcase
        end
    end

    // Saturating count of bad accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r <= 16'd0;
        end else if (err_s) begin
            err_count_r <= sat_inc16(err_count_r);
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count = err_count_r;

    // Refresh FSM: count READY cycles, then stall for REFRESH_CYCLES.
    // With refresh disabled the FSM stays in READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= READY;
            refresh_cnt_r <= '0;
            stall_cnt_r   <= '0;
        end else begin
            case (state_r)
                READY: begin
                    stall_cnt_r <= '0;
                    if (!REFRESH_EN) begin
                        refresh_cnt_r <= '0;
                    end else if (refresh_cnt_r == RP_LAST) begin
                        state_r       <= STALL;
                        refresh_cnt_r <= '0;
                    end else begin
                        refresh_cnt_r <= refresh_cnt_r + RP_W'(1);
                    end
                end
                STALL: begin
                    refresh_cnt_r <= '0;
                    if (stall_cnt_r == RC_LAST) begin
                        state_r     <= READY;
                        stall_cnt_r <= '0;
                    end else begin
                        stall_cnt_r <= stall_cnt_r + RC_W'(1);
                    end
                end
                default: begin
                    state_r       <= READY;
                    refresh_cnt_r <= '0;
                    stall_cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: scoreboard of expected read
// responses (data and return edge) checked against a response monitor.
`timescale 1ns/1ps
module tb_sdram_responder;
    import sdram_resp_pkg::*;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH);
`ifdef SDRAM_RESP_REFRESH_EN
    localparam int RP = 16;
`else
    localparam int RP = 256;
`endif
    localparam int RC = 4;

    typedef struct {
        logic [31:0] data;
        int          at_edge;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_responder_if bus();
    sdram_responder_if bus2();
    logic [15:0] err_count;
    logic [15:0] err_count2;

    sdram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(2),
                      .MAX_PENDING(4), .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC))
    dut (.clk(clk), .rst(rst), .bus(bus.slave), .err_count(err_count));

    sdram_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .READ_LATENCY(3),
                      .MAX_PENDING(1), .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC))
    dut2 (.clk(clk), .rst(rst), .bus(bus2.slave), .err_count(err_count2));

    int pass_cnt  = 0;
    int total_cnt = 0;
    int edge_n    = 0;
    rsp_t exp_q[$], rx_q[$], exp2_q[$], rx2_q[$];
    logic [31:0] model [int];

    always @(posedge clk) edge_n <= edge_n + 1;

    // Response monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.slave_readdatavalid === 1'b1) rx_q.push_back('{data: bus.slave_readdata, at_edge: edge_n});
        if (bus2.slave_readdatavalid === 1'b1) rx2_q.push_back('{data: bus2.slave_readdata, at_edge: edge_n});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic logic addr_valid(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (off[1:0] == 2'b00) && (off < SPAN);
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'(off >> 2);
    endfunction

    // Present a request from a falling edge and hold it until not stalled.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic saw_wait, output int acc_edge);
        logic ok;
        saw_wait = 1'b0;
        ok = 1'b0;
        @(negedge clk);
        bus.slave_read = rd; bus.slave_write = wr;
        bus.slave_address = addr; bus.slave_writedata = wdata;
        for (int t = 0; t < 64; t++) begin
            if (bus.slave_waitrequest === 1'b0) begin ok = 1'b1; break; end
            saw_wait = 1'b1;
            @(negedge clk);
        end
        acc_edge = edge_n + 1;
        if (!ok) begin
            total_cnt++;
            $display("FAIL accept_timeout: waitrequest stuck at %b, expected 0 within 64 cycles", bus.slave_waitrequest);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.slave_read = 1'b0; bus.slave_write = 1'b0;
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
        logic sw; int ae;
        issue(1'b0, 1'b1, addr, data, sw, ae);
        if (addr_valid(addr)) model[word_of(addr)] = data;
    endtask

    task automatic rd_word(input logic [31:0] addr, output logic sw);
        int ae;
        logic [31:0] d;
        issue(1'b1, 1'b0, addr, 32'd0, sw, ae);
        d = addr_valid(addr) ? model[word_of(addr)] : BAD_READ_DATA;
        exp_q.push_back('{data: d, at_edge: ae + 1});
    endtask

    task automatic settle();
        for (int t = 0; t < 60 && (rx_q.size() < exp_q.size() || rx2_q.size() < exp2_q.size()); t++)
            @(negedge clk);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.slave_read = 1'b0; bus.slave_write = 1'b0;
        bus.slave_address = 32'd0; bus.slave_writedata = 32'd0;
        bus2.slave_read = 1'b0; bus2.slave_write = 1'b0;
        bus2.slave_address = 32'd0; bus2.slave_writedata = 32'd0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (bus.slave_waitrequest !== 1'b1) $display("FAIL rst_wait: got %b, expected 1", bus.slave_waitrequest); else pass_cnt++;
        total_cnt++;
        if (bus.slave_readdatavalid !== 1'b0) $display("FAIL rst_rdv: got %b, expected 0", bus.slave_readdatavalid); else pass_cnt++;
        total_cnt++;
        if (bus.slave_readdata !== 32'd0) $display("FAIL rst_rdata: got %h, expected 0", bus.slave_readdata); else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd0) $display("FAIL rst_err: got %0d, expected 0", err_count); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.slave_waitrequest !== 1'b0) $display("FAIL rst_release_wait: got %b, expected 0", bus.slave_waitrequest); else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic sw;
        rsp_t e, r;
        wr_word(BASE + 32'h10, 32'h1234_5678);
        rd_word(BASE + 32'h10, sw);
        idle();
        settle();
        total_cnt++;
        if (rx_q.size() !== exp_q.size()) $display("FAIL wr_rd_count: got %0d, expected %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            total_cnt++;
            if (r.data !== e.data || r.at_edge !== e.at_edge)
                $display("FAIL wr_rd_data: got %h at edge %0d, expected %h at edge %0d", r.data, r.at_edge, e.data, e.at_edge);
            else pass_cnt++;
        end
        rx_q.delete(); exp_q.delete();
        total_cnt++;
        if (err_count !== 16'd0) $display("FAIL wr_rd_err: got %0d, expected 0", err_count); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic sw, any_wait;
        rsp_t e, r;
        int first_edge, last_edge;
        for (int i = 0; i < 10; i++) wr_word(BASE + 32'(4 * i), 32'hA000_0000 + 32'(i * 32'h111));
        any_wait = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_word(BASE + 32'(4 * i), sw);
            any_wait |= sw;
        end
        idle();
        settle();
        total_cnt++;
        if (rx_q.size() !== 10) $display("FAIL b2b_count: got %0d, expected 10", rx_q.size()); else pass_cnt++;
        first_edge = (rx_q.size() > 0) ? rx_q[0].at_edge : 0;
        last_edge  = (rx_q.size() > 0) ? rx_q[rx_q.size()-1].at_edge : 0;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            total_cnt++;
            if (r.data !== e.data || r.at_edge !== e.at_edge)
                $display("FAIL b2b_data: got %h at edge %0d, expected %h at edge %0d", r.data, r.at_edge, e.data, e.at_edge);
            else pass_cnt++;
        end
        rx_q.delete(); exp_q.delete();
`ifndef SDRAM_RESP_REFRESH_EN
        total_cnt++;
        if (any_wait !== 1'b0) $display("FAIL b2b_wait: got waitrequest %b, expected 0", any_wait); else pass_cnt++;
        total_cnt++;
        if (last_edge - first_edge !== 9) $display("FAIL b2b_span: got %0d edges, expected 9", last_edge - first_edge); else pass_cnt++;
`endif
    endtask

    task automatic test_errors();
        logic sw;
        int ae;
        rsp_t e, r;
        rd_word(BASE + SPAN, sw);
        wr_word(BASE + 32'h2, 32'hFFFF_FFFF);
        issue(1'b1, 1'b1, BASE + 32'h20, 32'h55AA_55AA, sw, ae);
        model[8] = 32'h55AA_55AA;
        idle();
        total_cnt++;
        if (err_count !== 16'd3) $display("FAIL err_three: got %0d, expected 3", err_count); else pass_cnt++;
        rd_word(BASE - 32'd4, sw);
        rd_word(BASE + 32'h20, sw);
        rd_word(BASE + 32'h0, sw);
        wr_word(BASE + SPAN - 32'd4, 32'hCAFE_F00D);
        rd_word(BASE + SPAN - 32'd4, sw);
        idle();
        settle();
        total_cnt++;
        if (rx_q.size() !== 5) $display("FAIL err_count_rsp: got %0d, expected 5", rx_q.size()); else pass_cnt++;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            total_cnt++;
            if (r.data !== e.data || r.at_edge !== e.at_edge)
                $display("FAIL err_data: got %h at edge %0d, expected %h at edge %0d", r.data, r.at_edge, e.data, e.at_edge);
            else pass_cnt++;
        end
        rx_q.delete(); exp_q.delete();
        total_cnt++;
        if (err_count !== 16'd4) $display("FAIL err_four: got %0d, expected 4", err_count); else pass_cnt++;
    endtask

    task automatic test_reset_inflight();
        logic sw;
        int ae;
        logic rdv_in_rst;
        rsp_t e, r;
        rd_word(BASE + 32'h10, sw);
        issue(1'b1, 1'b0, BASE + 32'h14, 32'd0, sw, ae);
        @(negedge clk);
        rst = 1'b1;
        bus.slave_read = 1'b0;
        rdv_in_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdv_in_rst |= (bus.slave_readdatavalid === 1'b1);
        end
        rst = 1'b0;
        settle();
        total_cnt++;
        if (rdv_in_rst !== 1'b0) $display("FAIL flush_rdv: got readdatavalid %b, expected 0", rdv_in_rst); else pass_cnt++;
        total_cnt++;
        if (rx_q.size() !== 1) $display("FAIL flush_count: got %0d responses, expected 1", rx_q.size()); else pass_cnt++;
        rx_q.delete(); exp_q.delete();
        rd_word(BASE + 32'h14, sw);
        idle();
        settle();
        total_cnt++;
        if (rx_q.size() !== 1) $display("FAIL post_rst_count: got %0d, expected 1", rx_q.size()); else pass_cnt++;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            total_cnt++;
            if (r.data !== e.data || r.at_edge !== e.at_edge)
                $display("FAIL post_rst_data: got %h at edge %0d, expected %h at edge %0d", r.data, r.at_edge, e.data, e.at_edge);
            else pass_cnt++;
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_pending_limit();
        int k, whigh;
        rsp_t e, r;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus2.slave_write = 1'b1; bus2.slave_read = 1'b0;
            bus2.slave_address = 32'(4 * i); bus2.slave_writedata = 32'h5000_0000 + 32'(i);
            for (int t = 0; t < 64 && bus2.slave_waitrequest !== 1'b0; t++) @(negedge clk);
        end
        @(negedge clk);
        bus2.slave_write = 1'b0;
        k = 0; whigh = 0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            bus2.slave_read = 1'b1;
            bus2.slave_address = 32'(4 * (k % 8));
            if (bus2.slave_waitrequest === 1'b1) whigh++;
            else begin
                exp2_q.push_back('{data: 32'h5000_0000 + 32'(k % 8), at_edge: edge_n + 3});
                k++;
            end
        end
        @(negedge clk);
        bus2.slave_read = 1'b0;
        settle();
`ifndef SDRAM_RESP_REFRESH_EN
        total_cnt++;
        if (whigh !== 20) $display("FAIL pend_wait_cycles: got %0d, expected 20", whigh); else pass_cnt++;
        total_cnt++;
        if (k !== 10) $display("FAIL pend_accepts: got %0d, expected 10", k); else pass_cnt++;
`endif
        total_cnt++;
        if (rx2_q.size() !== exp2_q.size()) $display("FAIL pend_count: got %0d, expected %0d", rx2_q.size(), exp2_q.size()); else pass_cnt++;
        while (rx2_q.size() > 0 && exp2_q.size() > 0) begin
            e = exp2_q.pop_front(); r = rx2_q.pop_front();
            total_cnt++;
            if (r.data !== e.data || r.at_edge !== e.at_edge)
                $display("FAIL pend_data: got %h at edge %0d, expected %h at edge %0d", r.data, r.at_edge, e.data, e.at_edge);
            else pass_cnt++;
        end
        rx2_q.delete(); exp2_q.delete();
    endtask

`ifdef SDRAM_RESP_REFRESH_EN
    task automatic test_refresh();
        logic exp_w;
        rsp_t e, r;
        @(negedge clk);
        rst = 1'b1;
        bus.slave_read = 1'b0; bus.slave_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_w = (i >= 16) && (((i - 16) % 20) < 4);
            total_cnt++;
            if (bus.slave_waitrequest !== exp_w)
                $display("FAIL refresh_wait: cycle %0d got %b, expected %b", i, bus.slave_waitrequest, exp_w);
            else pass_cnt++;
            bus.slave_read = 1'b1;
            bus.slave_address = BASE;
            if (bus.slave_waitrequest === 1'b0) exp_q.push_back('{data: model[0], at_edge: edge_n + 2});
        end
        idle();
        settle();
        total_cnt++;
        if (rx_q.size() !== exp_q.size()) $display("FAIL refresh_count: got %0d, expected %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            total_cnt++;
            if (r.data !== e.data || r.at_edge !== e.at_edge)
                $display("FAIL refresh_data: got %h at edge %0d, expected %h at edge %0d", r.data, r.at_edge, e.data, e.at_edge);
            else pass_cnt++;
        end
        rx_q.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        bus.slave_read = 1'b0; bus.slave_write = 1'b0;
        bus.slave_address = 32'd0; bus.slave_writedata = 32'd0;
        bus2.slave_read = 1'b0; bus2.slave_write = 1'b0;
        bus2.slave_address = 32'd0; bus2.slave_writedata = 32'd0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_errors();
        test_reset_inflight();
        test_pending_limit();
`ifdef SDRAM_RESP_REFRESH_EN
        test_refresh();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
